dsec_seq_ctrl: RTL
==================

DSEC_SEQ_CTRL -- requirements
Module: dsec_seq_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 1024, max cycles out_valid may wait for out_rcvd; 0 disables timeout.
REQ-002 Parameter ERR_NOKEY, default 64'h0000_0000_0000_00E1, code for data before three keys are loaded.
REQ-003 Parameter ERR_OVERRUN, default 64'h0000_0000_0000_00E2, code for a new block arriving while one is still unacknowledged.
REQ-004 Parameter ERR_TIMEOUT, default 64'h0000_0000_0000_00E3, code for an out_rcvd timeout.
REQ-005 One clock; reset is asynchronous and active-high; ports clk and rst.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 in_valid  in  1  host word valid on data bus.
REQ-009 key_config  in  1  qualifies the host word as a key word rather than data.
REQ-010 msg_end  in  1  one-cycle pulse: flush the current message.
REQ-011 out_rcvd  in  1  host has taken the output word.
REQ-012 comp_rdy  in  1  compressor can accept a word.
REQ-013 scon_done  in  1  one-cycle pulse: packed 64-bit block ready for encryption/output.
REQ-014 rdy  out  1  host handshake ready.
REQ-015 key_we  out  1  key register write strobe.
REQ-016 key_sel  out  2  key register index: 1, 2 or 3 when key_we=1, else 0.
REQ-017 comp_valid  out  1  word forwarded to compressor.
REQ-018 dump_comp  out  1  compressor/packer flush request.
REQ-019 stall  out  1  freezes compressor and packer.
REQ-020 out_valid  out  1  output word valid.
REQ-021 error  out  1  sticky error flag.
REQ-022 error_code  out  64  error code driven on data_out when error=1.

Function
REQ-023 The block SHALL use states IDLE, STREAM, DRAIN and ERROR, plus a 2-bit key_idx, a keys_loaded flag and an ack-pending flag (ack-pending drives both out_valid and stall).
REQ-024 rdy SHALL be (IDLE or STREAM) and !out_valid and comp_rdy; a host word is accepted only on a cycle with in_valid and rdy.
REQ-025 An accepted word with key_config=1 SHALL pulse key_we for one cycle with key_sel=key_idx+1, then key_idx increments and wraps 2->0; keys_loaded sets on the third key and stays set until rst.
REQ-026 An accepted word with key_config=0 and keys_loaded=1 SHALL pulse comp_valid in the next cycle and move IDLE->STREAM.
REQ-027 An accepted word with key_config=0 and keys_loaded=0 SHALL enter ERROR with error_code=ERR_NOKEY.
REQ-028 msg_end in STREAM SHALL move to DRAIN and assert dump_comp from the next cycle until the cycle after the next scon_done; msg_end in IDLE, DRAIN or ERROR is ignored.
REQ-029 On scon_done with out_valid=0, out_valid and stall SHALL be set the next cycle and remain set through the cycle out_rcvd=1, clearing the cycle after.
REQ-030 On scon_done with out_valid=1 and out_rcvd=0 in the same cycle, the block SHALL enter ERROR with ERR_OVERRUN; scon_done coincident with out_rcvd re-arms out_valid with no gap.
REQ-031 A timeout counter SHALL count cycles with out_valid=1 and out_rcvd=0 and reset on out_rcvd; reaching TIMEOUT enters ERROR with ERR_TIMEOUT.
REQ-032 DRAIN SHALL return to IDLE the cycle after out_rcvd acknowledges the flushed block; keys and keys_loaded are retained.
REQ-033 ERROR SHALL be terminal until rst: error=1, rdy=0, comp_valid=0, key_we=0, stall=1, out_valid=0, and error_code is held; on simultaneous error causes, priority is OVERRUN > TIMEOUT > NOKEY.
REQ-034 All outputs except rdy SHALL be registered; rdy is combinational from registered state and comp_rdy.

Reset
REQ-035 rst SHALL immediately force IDLE, key_idx=0, keys_loaded=0, ack-pending=0, timeout count=0, and all outputs to 0 (rdy may rise once rst deasserts and comp_rdy=1).
REQ-036 rst mid-key-load or mid-message SHALL discard the partial state; a full three-key load is required afterward.

Verification
REQ-037 Three key_config words, then data A -> key_we pulses with key_sel 1,2,3; one comp_valid pulse; state moves to STREAM.
REQ-038 Data word before keys -> error=1, error_code=64'h00E1 the next cycle, rdy=0 until rst.
REQ-039 scon_done, out_rcvd held low 3 cycles then high -> out_valid and stall high for 4 cycles, rdy=0 throughout, clear the following cycle.
REQ-040 Second scon_done while out_valid=1 and out_rcvd=0 -> error_code=64'h00E2.
REQ-041 TIMEOUT=8 with no out_rcvd -> error_code=64'h00E3 after 8 waiting cycles.
REQ-042 msg_end in STREAM, scon_done 5 cycles later, out_rcvd -> dump_comp high 6 cycles, IDLE the cycle after out_rcvd, keys still loaded (next data word accepted without error).

Source files
------------

// File: rtl/dsec_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dsec_seq_ctrl
//
// Sequencing controller for the data-security datapath. It loads three key
// words, forwards data words to the compressor, flushes the compressor and
// packer at the end of a message, and holds each packed 64-bit block on the
// output until the host acknowledges it. Protocol violations (data before
// keys, block overrun, acknowledge timeout) latch a terminal error state that
// only rst clears.
//
// Parameters
//   TIMEOUT      max cycles out_valid may wait for out_rcvd (0 = no limit)
//   ERR_NOKEY    error code: data word arrived before three keys were loaded
//   ERR_OVERRUN  error code: new block arrived while one was unacknowledged
//   ERR_TIMEOUT  error code: out_rcvd not seen within TIMEOUT cycles
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   in_valid    in   host word valid on the data bus
//   key_config  in   host word is a key word rather than data
//   msg_end     in   one-cycle pulse: flush the current message
//   out_rcvd    in   host has taken the output word
//   comp_rdy    in   compressor can accept a word
//   scon_done   in   one-cycle pulse: packed 64-bit block ready
//   rdy         out  host handshake ready (combinational)
//   key_we      out  key register write strobe
//   key_sel     out  key register index 1..3 while key_we=1, else 0
//   comp_valid  out  word forwarded to the compressor
//   dump_comp   out  compressor/packer flush request
//   stall       out  freezes compressor and packer
//   out_valid   out  output word valid
//   error       out  sticky error flag
//   error_code  out  error code, driven on data_out while error=1
// -----------------------------------------------------------------------------
module dsec_seq_ctrl #(
  parameter int unsigned TIMEOUT     = 1024,
  parameter logic [63:0] ERR_NOKEY   = 64'h0000_0000_0000_00E1,
  parameter logic [63:0] ERR_OVERRUN = 64'h0000_0000_0000_00E2,
  parameter logic [63:0] ERR_TIMEOUT = 64'h0000_0000_0000_00E3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        key_config,
  input  logic        msg_end,
  input  logic        out_rcvd,
  input  logic        comp_rdy,
  input  logic        scon_done,
  output logic        rdy,
  output logic        key_we,
  output logic [1:0]  key_sel,
  output logic        comp_valid,
  output logic        dump_comp,
  output logic        stall,
  output logic        out_valid,
  output logic        error,
  output logic [63:0] error_code
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    ERROR  = 2'd3
  } state_t;

  // The wait counter only needs to reach TIMEOUT-1: the error fires on the
  // waiting cycle that finds it there.
  localparam int unsigned   CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t        state, state_nxt;
  logic [1:0]    key_idx, key_idx_nxt;
  logic          keys_loaded, keys_loaded_nxt;
  logic [CW-1:0] to_cnt, to_cnt_nxt;
  logic          dump_clr, dump_clr_nxt;     // scon_done seen while flushing
  logic          flush_wait, flush_wait_nxt; // flushed block is on the output

  logic          key_we_nxt;
  logic [1:0]    key_sel_nxt;
  logic          comp_valid_nxt;
  logic          dump_nxt;
  logic          stall_nxt;
  logic          ack_nxt;
  logic          error_nxt;
  logic [63:0]   error_code_nxt;

  logic accept;
  logic wait_cyc;
  logic overrun;
  logic timeout_hit;
  logic nokey;

  // rdy is held low during reset so the host never sees a handshake before
  // the state registers are known.
  assign rdy = !rst && ((state == IDLE) || (state == STREAM)) && !out_valid && comp_rdy;

  assign accept      = in_valid && rdy;
  assign wait_cyc    = out_valid && !out_rcvd;
  assign overrun     = scon_done && out_valid && !out_rcvd;
  assign timeout_hit = (TIMEOUT != 0) && wait_cyc && (to_cnt == TO_LAST);
  assign nokey       = accept && !key_config && !keys_loaded;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    state_nxt       = state;
    key_idx_nxt     = key_idx;
    keys_loaded_nxt = keys_loaded;
    to_cnt_nxt      = '0;
    dump_clr_nxt    = 1'b0;
    flush_wait_nxt  = flush_wait;
    key_we_nxt      = 1'b0;
    key_sel_nxt     = 2'd0;
    comp_valid_nxt  = 1'b0;
    dump_nxt        = dump_comp;
    ack_nxt         = out_valid;
    error_nxt       = error;
    error_code_nxt  = error_code;

    if (state == ERROR) begin
      // Terminal: everything quiet except stall and the held error code.
      ack_nxt        = 1'b0;
      dump_nxt       = 1'b0;
      flush_wait_nxt = 1'b0;
    end else begin
      // Output handshake: a new block (re)arms, an acknowledge clears. A
      // block landing on the acknowledge cycle keeps out_valid high.
      if (scon_done) begin
        ack_nxt = 1'b1;
      end else if (out_rcvd) begin
        ack_nxt = 1'b0;
      end

      if (wait_cyc) begin
        to_cnt_nxt = to_cnt + 1'b1;
      end

      if (accept) begin
        if (key_config) begin
          key_we_nxt  = 1'b1;
          key_sel_nxt = key_idx + 2'd1;
          key_idx_nxt = (key_idx == 2'd2) ? 2'd0 : key_idx + 2'd1;
          if (key_idx == 2'd2) begin
            keys_loaded_nxt = 1'b1;
          end
        end else if (keys_loaded) begin
          comp_valid_nxt = 1'b1;
          if (state == IDLE) begin
            state_nxt = STREAM;
          end
        end
      end

      // dump_comp runs from the cycle after msg_end through the cycle after
      // the flushed block arrives, hence the one-cycle-delayed clear.
      if (dump_comp && scon_done) begin
        dump_clr_nxt = 1'b1;
      end
      if (dump_clr) begin
        dump_nxt = 1'b0;
      end

      if ((state == STREAM) && msg_end) begin
        state_nxt = DRAIN;
        dump_nxt  = 1'b1;
      end

      // Leave DRAIN only on the acknowledge of the block produced by the
      // flush, not of a block that was already pending at msg_end.
      if ((state == DRAIN) && scon_done) begin
        flush_wait_nxt = 1'b1;
      end
      if ((state == DRAIN) && flush_wait && out_valid && out_rcvd) begin
        state_nxt      = IDLE;
        flush_wait_nxt = 1'b0;
      end

      if (overrun || timeout_hit || nokey) begin
        state_nxt      = ERROR;
        error_nxt      = 1'b1;
        ack_nxt        = 1'b0;
        dump_nxt       = 1'b0;
        flush_wait_nxt = 1'b0;
        key_we_nxt     = 1'b0;
        key_sel_nxt    = 2'd0;
        comp_valid_nxt = 1'b0;
        if (overrun) begin
          error_code_nxt = ERR_OVERRUN;
        end else if (timeout_hit) begin
          error_code_nxt = ERR_TIMEOUT;
        end else begin
          error_code_nxt = ERR_NOKEY;
        end
      end
    end

    stall_nxt = ack_nxt || (state_nxt == ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      key_idx     <= 2'd0;
      keys_loaded <= 1'b0;
      to_cnt      <= '0;
      dump_clr    <= 1'b0;
      flush_wait  <= 1'b0;
      key_we      <= 1'b0;
      key_sel     <= 2'd0;
      comp_valid  <= 1'b0;
      dump_comp   <= 1'b0;
      stall       <= 1'b0;
      out_valid   <= 1'b0;
      error       <= 1'b0;
      error_code  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state       <= state_nxt;
      key_idx     <= key_idx_nxt;
      keys_loaded <= keys_loaded_nxt;
      to_cnt      <= to_cnt_nxt;
      dump_clr    <= dump_clr_nxt;
      flush_wait  <= flush_wait_nxt;
      key_we      <= key_we_nxt;
      key_sel     <= key_sel_nxt;
      comp_valid  <= comp_valid_nxt;
      dump_comp   <= dump_nxt;
      stall       <= stall_nxt;
      out_valid   <= ack_nxt;
      error       <= error_nxt;
      error_code  <= error_code_nxt;
    end
  end

endmodule
